// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   SYNC_BYTE - frame start marker
//   state_t   - loader FSM states
//   *_W       - frame field / datapath widths
package loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam int BYTE_W = 8;
   localparam int LEN_W  = 16;
   localparam int WORD_W = 32;
   localparam int LANES  = WORD_W / BYTE_W;
   localparam int LANE_W = $clog2(LANES);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      CSUM,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/byte_to_word.sv
// Little-endian 4-lane byte assembler.
//   clk, rst   - clock, async active-low reset
//   clear      - restart at lane 0 with an empty word
//   shift      - store din into the current lane and advance
//   din        - incoming byte
//   word       - assembled word, first byte in [7:0]
//   last       - current lane is the top lane (next shift completes a word)
module byte_to_word
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              shift,
   input  logic [BYTE_W-1:0] din,
   output logic [WORD_W-1:0] word,
   output logic              last
);

   logic [LANE_W-1:0] lane;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word <= '0;
         lane <= '0;
      end else if (clear) begin
         word <= '0;
         lane <= '0;
      end else if (shift) begin
         word[lane*BYTE_W +: BYTE_W] <= din;
         lane                        <= lane + 1'b1;  // wraps to 0 after top lane
      end
   end

   assign last = (lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory writer. Parses SYNC/LEN/payload/CSUM frames from a
// valid/ready byte stream, writes little-endian words to memory and keeps the
// CPU in reset until a checksum-verified image is present.
//   clk, rst            - clock, async active-low reset
//   in_data/valid/ready - byte stream handshake
//   mem_we/waddr/wdata  - instruction-memory write port (one-cycle strobe)
//   cpu_hold            - CPU reset request
//   load_done/load_err  - verified image / framing, length or checksum failure
module inst_mem_loader
   import loader_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   state_t             state, nxt;
   logic [LEN_W-1:0]   len, word_cnt;
   logic [BYTE_W-1:0]  csum;
   logic [LEN_W-1:0]   len_full;
   logic               acc, is_sync, start, lane_last;

   assign acc      = in_valid & in_ready;
   assign is_sync  = (in_data == SYNC_BYTE);
   assign len_full = {in_data, len[BYTE_W-1:0]};
   // A sync byte opens a new frame from any resting state.
   assign start    = acc & is_sync & (state == IDLE || state == DONE || state == ERR);

   byte_to_word u_asm (
      .clk   (clk),
      .rst   (rst),
      .clear (start),
      .shift (acc && state == DATA),
      .din   (in_data),
      .word  (mem_wdata),
      .last  (lane_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start) nxt = LEN_LO;
         LEN_LO:          if (acc)   nxt = LEN_HI;
         LEN_HI: if (acc) begin
            if (32'(len_full) > MAX_WORDS) nxt = ERR;
            else if (len_full == '0)       nxt = CSUM;
            else                           nxt = DATA;
         end
         DATA:   if (acc && lane_last) nxt = WRITE;
         WRITE:  nxt = (word_cnt + 1'b1 == len) ? CSUM : DATA;
         CSUM:   if (acc) nxt = (in_data == csum) ? DONE : ERR;
         default: nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_waddr <= ADDR_W'(BASE_ADDR);
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         len       <= '0;
         word_cnt  <= '0;
         csum      <= '0;
      end else begin
         in_ready  <= (nxt != WRITE);
         mem_we    <= (nxt == WRITE);
         cpu_hold  <= (nxt != DONE);
         load_done <= (nxt == DONE);
         load_err  <= (nxt == ERR);
         if (nxt == WRITE)
            mem_waddr <= ADDR_W'(BASE_ADDR) + ADDR_W'({word_cnt, 2'b00});
         if (start) begin
            csum     <= '0;
            word_cnt <= '0;
         end
         if (acc && state == LEN_LO) len[BYTE_W-1:0]      <= in_data;
         if (acc && state == LEN_HI) len[LEN_W-1:BYTE_W]  <= in_data;
         if (acc && state == DATA)   csum                 <= csum ^ in_data;
         if (state == WRITE)         word_cnt             <= word_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, mem_we, cpu_hold, load_done, load_err;
   logic [9:0]  mem_waddr;
   logic [31:0] mem_wdata;

   int tests = 0;
   int fails = 0;

   // write log filled by the monitor
   logic [9:0]  wa [16];
   logic [31:0] wd [16];
   int          wn = 0;
   int          w0;
   // handshake rule check: in_ready low exactly in write cycles
   logic        rdy_chk = 1'b0;
   int          rdy_bad = 0;

   inst_mem_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(256)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         if (wn < 16) begin
            wa[wn] = mem_waddr;
            wd[wn] = mem_wdata;
         end
         wn = wn + 1;
      end
      if (rdy_chk && (in_ready !== !mem_we)) rdy_bad = rdy_bad + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte is accepted.
   task automatic send(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   logic [7:0] good [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h03, 8'h10, 8'h00,
                             8'h33, 8'h03, 8'h63, 8'h00, 8'h53};

   task automatic send_good(input logic [7:0] cs, input int stall);
      for (int i = 0; i < 12; i++) begin
         // stall mode: gap every other cycle, longer gap before payload byte 2 of word 0
         send((i == 11) ? cs : good[i], stall == 0 ? 0 : (i == 5 ? 3 : 1));
      end
      @(negedge clk);
   endtask

   task automatic chk_writes(input string tag);
      chk({tag, "_wcount"}, 32'(wn - w0), 32'd2);
      chk({tag, "_a0"}, 32'(wa[w0]),     32'h000);
      chk({tag, "_d0"}, wd[w0],          32'h00100313);
      chk({tag, "_a1"}, 32'(wa[w0 + 1]), 32'h004);
      chk({tag, "_d1"}, wd[w0 + 1],      32'h00630333);
   endtask

   task automatic chk_status(input string tag, input logic d, input logic e, input logic h);
      chk({tag, "_done"}, 32'(load_done), 32'(d));
      chk({tag, "_err"},  32'(load_err),  32'(e));
      chk({tag, "_hold"}, 32'(cpu_hold),  32'(h));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(in_ready),  32'd0);
      chk({tag, "_we"},    32'(mem_we),    32'd0);
      chk({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
      chk({tag, "_wdata"}, mem_wdata,      32'd0);
      chk_status(tag, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", 32'(in_ready), 32'd1);

      // garbage then empty frame
      w0 = wn;
      send(8'h00, 0); send(8'hFF, 0); send(8'h13, 0);
      chk_status("garbage", 1'b0, 1'b0, 1'b1);
      send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
      @(negedge clk);
      chk("empty_wcount", 32'(wn - w0), 32'd0);
      chk_status("empty", 1'b1, 1'b0, 1'b0);

      // two-word load, contiguous
      w0 = wn;
      send_good(8'h53, 0);
      chk_writes("load");
      chk_status("load", 1'b1, 1'b0, 1'b0);

      // bad checksum: writes still happen, then error
      w0 = wn;
      send_good(8'h54, 0);
      chk_writes("badcs");
      chk_status("badcs", 1'b0, 1'b1, 1'b1);

      // oversize length: error right after LEN_HI
      w0 = wn;
      send(8'hA5, 0); send(8'h01, 0);
      chk("len_lo_hold", 32'(cpu_hold), 32'd1);
      send(8'h01, 0);
      chk("big_err_now", 32'(load_err), 32'd1);
      repeat (4) @(negedge clk);
      chk("big_wcount", 32'(wn - w0), 32'd0);
      chk_status("big", 1'b0, 1'b1, 1'b1);

      // stalled load
      w0 = wn;
      rdy_chk = 1'b1;
      send_good(8'h53, 1);
      rdy_chk = 1'b0;
      chk_writes("stall");
      chk_status("stall", 1'b1, 1'b0, 1'b0);
      chk("stall_ready_rule", 32'(rdy_bad), 32'd0);

      // reset mid-frame after 6 payload bytes
      for (int i = 0; i < 9; i++) send(good[i], 0);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrst");
      rst = 1'b1;
      @(negedge clk);
      w0 = wn;
      send_good(8'h53, 0);
      chk_writes("after_rst");
      chk_status("after_rst", 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
